// File: rtl/decoder_2_4_strobe.sv
// decoder_2_4_strobe
// Registered binary-to-one-hot strobe decoder with a valid/ready handshake.
// An accepted code drives exactly one of 2**CODE_W lines high for PULSE_LEN
// cycles, starting the cycle after the accept.
//
// Optional build macro DEC_GAP_EN: when defined, every completed strobe is
// followed by a one-cycle GAP state. That guarantees a zero cycle between
// strobes, and back-to-back reload is disabled.

module decoder_2_4_strobe #(
   parameter int CODE_W    = 2,
   parameter int PULSE_LEN = 3
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [CODE_W-1:0]      in_code,
   output logic [2**CODE_W-1:0]   y,
   output logic                   busy,
   output logic                   done
);

   localparam int OUT_W = 2**CODE_W;
   localparam int CNT_W = $clog2(PULSE_LEN + 1);

   // The counter holds the number of strobe cycles still to come after the
   // current one, so it is loaded with PULSE_LEN-1 and reads zero in the last
   // strobe cycle.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [OUT_W-1:0] ONE_BIT  = OUT_W'(1);

   // A one-cycle strobe is also its own last cycle, so done rises together
   // with y.
   localparam logic FIRST_DONE = (PULSE_LEN == 1);

`ifdef DEC_GAP_EN
   localparam logic RELOAD_OK = 1'b0;
   typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
`else
   localparam logic RELOAD_OK = 1'b1;
   typedef enum logic [1:0] {IDLE, PULSE} state_t;
`endif

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] one_hot;
   logic             accept;

   assign one_hot = ONE_BIT << in_code;
   assign accept  = in_valid & in_ready;

   // A new code is taken when idle, or in the last strobe cycle when
   // back-to-back reload is allowed. Reset and a low enable both refuse it.
   always_comb begin
      in_ready = 1'b0;
      if (en && !rst) begin
         if (state == IDLE)
            in_ready = 1'b1;
         else if (state == PULSE && cnt == '0 && RELOAD_OK)
            in_ready = 1'b1;
      end
   end

   // Strobe FSM: it loads on accept, counts down through the pulse, and then
   // either reloads, rests in GAP, or returns to IDLE. A low enable aborts
   // the strobe without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         y     <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  state <= PULSE;
                  y     <= one_hot;
                  cnt   <= CNT_LOAD;
                  busy  <= 1'b1;
                  done  <= FIRST_DONE;
               end
            end
            PULSE: begin
               if (!en) begin
                  state <= IDLE;
                  y     <= '0;
                  cnt   <= '0;
                  busy  <= 1'b0;
               end else if (cnt != '0) begin
                  cnt  <= cnt - CNT_ONE;
                  done <= (cnt == CNT_ONE);
               end else if (accept) begin
                  y    <= one_hot;
                  cnt  <= CNT_LOAD;
                  busy <= 1'b1;
                  done <= FIRST_DONE;
               end else begin
`ifdef DEC_GAP_EN
                  state <= GAP;
`else
                  state <= IDLE;
`endif
                  y     <= '0;
                  busy  <= 1'b0;
               end
            end
`ifdef DEC_GAP_EN
            GAP: begin
               state <= IDLE;
            end
`endif
            default: begin
               state <= IDLE;
               y     <= '0;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_decoder_2_4_strobe.sv
// tb_decoder_2_4_strobe
// Drives two decoders from the same inputs: PULSE_LEN=3 and PULSE_LEN=1.
// Each decoder is compared every cycle against a reference model. The model
// tracks how many strobe cycles remain for the current code; it does not
// model the decoder's state machine.

module tb_decoder_2_4_strobe;

`ifdef DEC_GAP_EN
   localparam bit GAP_MODE = 1'b1;
`else
   localparam bit GAP_MODE = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic       in_valid;
   logic [1:0] in_code;

   logic [3:0] y0, y1;
   logic       busy0, busy1, done0, done1, rdy0, rdy1;

   int total = 0;
   int bad   = 0;

   // reference model state, index 0 = PULSE_LEN 3, index 1 = PULSE_LEN 1
   int rem[2];
   int mcode[2];
   bit gap[2];
   int plen[2] = '{3, 1};

   decoder_2_4_strobe #(.CODE_W(2), .PULSE_LEN(3)) dut0 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy0),
      .in_code(in_code), .y(y0), .busy(busy0), .done(done0)
   );

   decoder_2_4_strobe #(.CODE_W(2), .PULSE_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy1),
      .in_code(in_code), .y(y1), .busy(busy1), .done(done1)
   );

   // free-running clock
   always #5 clk = ~clk;

   function automatic bit modelReady(int i);
      return en && !rst && ((rem[i] == 0 && !gap[i]) || (rem[i] == 1 && !GAP_MODE));
   endfunction

   function automatic logic [3:0] modelY(int i);
      return (rem[i] > 0) ? (4'b0001 << mcode[i]) : 4'b0000;
   endfunction

   task automatic modelStep(input bit r0, input bit r1);
      bit rdy[2];
      rdy[0] = r0;
      rdy[1] = r1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            rem[i] = 0;
            gap[i] = 1'b0;
         end else if (rem[i] > 0 && !en) begin
            rem[i] = 0;
         end else if (rdy[i] && in_valid) begin
            rem[i]   = plen[i];
            mcode[i] = int'(in_code);
         end else if (rem[i] > 0) begin
            if (rem[i] == 1 && GAP_MODE) gap[i] = 1'b1;
            rem[i] = rem[i] - 1;
         end else if (gap[i]) begin
            gap[i] = 1'b0;
         end
      end
   endtask

   task automatic checkOne(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkOutput();
      checkOne("y0",    16'(y0),    16'(modelY(0)));
      checkOne("busy0", 16'(busy0), 16'(rem[0] > 0));
      checkOne("done0", 16'(done0), 16'(rem[0] == 1));
      checkOne("rdy0",  16'(rdy0),  16'(modelReady(0)));
      checkOne("y1",    16'(y1),    16'(modelY(1)));
      checkOne("busy1", 16'(busy1), 16'(rem[1] > 0));
      checkOne("done1", 16'(done1), 16'(rem[1] == 1));
      checkOne("rdy1",  16'(rdy1),  16'(modelReady(1)));
   endtask

   task automatic applyStimulus(input bit r, input bit e, input bit v, input logic [1:0] c);
      bit r0, r1;
      rst      = r;
      en       = e;
      in_valid = v;
      in_code  = c;
      #2;
      checkOutput();
      r0 = modelReady(0);
      r1 = modelReady(1);
      @(posedge clk);
      modelStep(r0, r1);
      #1;
   endtask

   initial begin
      logic [3:0] expY;

      rem   = '{0, 0};
      mcode = '{0, 0};
      gap   = '{1'b0, 1'b0};

      // bring both decoders out of the unknown power-up state
      rst = 1'b1; en = 1'b1; in_valid = 1'b1; in_code = 2'd0;
      @(posedge clk);
      modelStep(1'b0, 1'b0);
      #1;

      $display("[TB] reset held with in_valid and en high");
      applyStimulus(1, 1, 1, 2'd1);
      checkOne("rst_rdy_lit", 16'(rdy0), 16'd0);
      applyStimulus(1, 1, 1, 2'd2);
      checkOne("rst_y_lit", 16'(y0), 16'd0);
      applyStimulus(0, 1, 0, 2'd0);

      $display("[TB] single strobe, code 2");
      applyStimulus(0, 1, 1, 2'd2);
      checkOne("t2_y_c1", 16'(y0), 16'b0100);
      checkOne("t2_done_c1", 16'(done0), 16'd0);
      applyStimulus(0, 1, 0, 2'd3);
      checkOne("t2_y_c2", 16'(y0), 16'b0100);
      applyStimulus(0, 1, 0, 2'd0);
      checkOne("t2_y_c3", 16'(y0), 16'b0100);
      checkOne("t2_done_c3", 16'(done0), 16'd1);
      applyStimulus(0, 1, 0, 2'd0);
      checkOne("t2_y_c4", 16'(y0), 16'd0);
      checkOne("t2_busy_c4", 16'(busy0), 16'd0);
      applyStimulus(0, 1, 0, 2'd0);

      $display("[TB] back-to-back codes 0 then 3");
      applyStimulus(0, 1, 1, 2'd0);
      for (int i = 0; i < 8; i++) applyStimulus(0, 1, 1, 2'd3);
      for (int i = 0; i < 6; i++) applyStimulus(0, 1, 0, 2'd0);

      $display("[TB] enable dropped mid-strobe");
      applyStimulus(0, 1, 1, 2'd1);
      applyStimulus(0, 1, 0, 2'd1);
      applyStimulus(0, 0, 0, 2'd1);
      checkOne("t4_done_abort", 16'(done0), 16'd0);
      for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 2'd2);
      checkOne("t4_y_idle", 16'(y0), 16'd0);
      applyStimulus(0, 1, 0, 2'd0);

      $display("[TB] reset mid-strobe then fresh accept");
      applyStimulus(0, 1, 1, 2'd3);
      applyStimulus(0, 1, 0, 2'd3);
      applyStimulus(1, 1, 0, 2'd3);
      checkOne("t5_busy_rst", 16'(busy0), 16'd0);
      applyStimulus(0, 1, 1, 2'd1);
      for (int i = 0; i < 5; i++) applyStimulus(0, 1, 0, 2'd0);

      $display("[TB] code sweep with in_valid held");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 1, 1, 2'(i));
         if (!GAP_MODE) begin
            expY = 4'b0001 << i;
            checkOne("t6_y1_sweep", 16'(y1), 16'(expY));
            checkOne("t6_done1_sweep", 16'(done1), 16'd1);
         end
      end
      for (int i = 0; i < 4; i++) applyStimulus(0, 1, 0, 2'd0);

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         applyStimulus(($urandom_range(0, 39) == 0),
                       ($urandom_range(0, 9) != 0),
                       ($urandom_range(0, 2) != 0),
                       2'($urandom));
      end
      applyStimulus(0, 1, 0, 2'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
